// File: rtl/lsu_pkg.sv
// lsu_pkg: op encodings, FSM states, memory map defaults
// and small decode helpers shared by the LSU files.
package lsu_pkg;

   localparam logic [31:0] BASE_ADDR_DEF   = 32'h1001_0000;
   localparam int          DEPTH_WORDS_DEF = 1024;

   typedef enum logic [2:0] {
      OP_LB  = 3'b000,
      OP_LH  = 3'b001,
      OP_LW  = 3'b010,
      OP_SB  = 3'b011,
      OP_LBU = 3'b100,
      OP_LHU = 3'b101,
      OP_SH  = 3'b110,
      OP_SW  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_ACCESS    = 2'b01,
      S_RMW_WRITE = 2'b10,
      S_RESP      = 2'b11
   } state_e;

   function automatic logic is_store(op_e op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(op_e op,
                                          logic [1:0] lo);
      logic r;
      r = 1'b0;
      case (op)
         OP_LW, OP_SW:          r = (lo != 2'b00);
         OP_LH, OP_LHU, OP_SH:  r = lo[0];
         default:               r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: pipeline request/response and data-memory bus.
// slave = LSU side, master = pipeline + memory side.
interface lsu_ctrl_if;
   import lsu_pkg::*;

   logic        req;
   op_e         op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   modport slave (
      input  req, op, addr, wdata, mem_rdata,
      output busy, done, rdata, fault,
             mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req, op, addr, wdata, mem_rdata,
      input  busy, done, rdata, fault,
             mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane extract/extend for loads
// and lane merge for SB/SH. Ports: op, byte_off, word, wdata
// in; load_data, merged out. Purely combinational.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  op_e         op,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b    = word[{byte_off, 3'b000} +: 8];
      lane_h    = byte_off[1] ? word[31:16] : word[15:0];
      load_data = word;
      merged    = word;
      case (op)
         OP_LB:  load_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU: load_data = {24'h0, lane_b};
         OP_LH:  load_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU: load_data = {16'h0, lane_h};
         OP_SB:  merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
         OP_SH:  merged[{byte_off[1], 4'b0000} +: 16] =
                    wdata[15:0];
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit FSM with request latch, range and
// alignment check. Ports: clock, reset, bus (lsu_ctrl_if.slave).
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF
)
(
   input logic        clock,
   input logic        reset,
   lsu_ctrl_if.slave  bus
);

   localparam logic [31:0] LAST_ADDR =
      BASE_ADDR + 32'(DEPTH_WORDS * 4) - 32'd1;

   state_e      state_q, state_d;
   op_e         op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        fault_q;
   logic [31:0] rdata_q;
   logic [31:0] merge_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   logic        accept;
   logic        req_fault;
   logic [31:0] word_addr;
   logic [31:0] load_data;
   logic [31:0] merged;
   logic        busy_c;
   logic        done_c;
   logic        mem_we_c;
   logic [31:0] mem_wdata_c;

   assign accept = bus.req &&
                   ((state_q == S_IDLE) || (state_q == S_RESP));

   assign req_fault = is_misaligned(bus.op, bus.addr[1:0]) ||
                      (bus.addr < BASE_ADDR) ||
                      (bus.addr > LAST_ADDR);

   assign word_addr = {addr_q[31:2], 2'b00};

   lsu_byte_lane u_lane (
      .op        (op_q),
      .byte_off  (addr_q[1:0]),
      .word      (bus.mem_rdata),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      mem_we_c    = 1'b0;
      mem_wdata_c = mem_wdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept)
               state_d = req_fault ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            busy_c = 1'b1;
            if (op_q == OP_SB || op_q == OP_SH) begin
               state_d = S_RMW_WRITE;
            end else begin
               state_d = S_RESP;
               if (op_q == OP_SW) begin
                  mem_we_c    = 1'b1;
                  mem_wdata_c = wdata_q;
               end
            end
         end
         S_RMW_WRITE: begin
            busy_c      = 1'b1;
            mem_we_c    = 1'b1;
            mem_wdata_c = merge_q;
            state_d     = S_RESP;
         end
         S_RESP: begin
            done_c = 1'b1;
            if (accept)
               state_d = req_fault ? S_RESP : S_ACCESS;
            else
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // mem_addr/mem_wdata hold their last driven value outside
   // the access states, so the *_q copies track what was driven.
   always_ff @(posedge clock) begin
      if (reset) begin
         op_q        <= OP_LB;
         addr_q      <= '0;
         wdata_q     <= '0;
         fault_q     <= 1'b0;
         rdata_q     <= '0;
         merge_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         if (accept) begin
            op_q    <= bus.op;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            fault_q <= req_fault;
            rdata_q <= '0;
         end
         if (busy_c)
            mem_addr_q <= word_addr;
         if (mem_we_c)
            mem_wdata_q <= mem_wdata_c;
         if (state_q == S_ACCESS) begin
            if (!is_store(op_q))
               rdata_q <= load_data;
            merge_q <= merged;
         end
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.fault     = done_c & fault_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_wdata = mem_wdata_c;
   assign bus.mem_addr  = busy_c ? word_addr : mem_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with
// a small word-addressed data memory model.
module tb_lsu_ctrl;
   import lsu_pkg::*;

   localparam logic [31:0] BASE = 32'h1001_0000;

   logic clk;
   logic rst;
   lsu_ctrl_if bus ();

   lsu_ctrl #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (1024)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [1024];
   logic [9:0]  midx;
   int          we_cnt;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   assign midx = 10'((bus.mem_addr - BASE) >> 2);
   assign bus.mem_rdata = mem[midx];

   initial begin
      we_cnt  = 0;
      wr_addr = '0;
      wr_data = '0;
   end

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem[midx] <= bus.mem_wdata;
         we_cnt    <= we_cnt + 1;
         wr_addr   <= bus.mem_addr;
         wr_data   <= bus.mem_wdata;
      end
   end

   int n_chk;
   int n_fail;

   task automatic run_op(input op_e op, input logic [31:0] a,
                         input logic [31:0] wd,
                         output int lat,
                         output logic [31:0] rd,
                         output logic flt);
      @(negedge clk);
      bus.req   = 1'b1;
      bus.op    = op;
      bus.addr  = a;
      bus.wdata = wd;
      @(posedge clk);
      lat = -1;
      rd  = '0;
      flt = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         bus.req = 1'b0;
         if (bus.done) begin
            lat = i;
            rd  = bus.rdata;
            flt = bus.fault;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({bus.busy, bus.done, bus.fault, bus.mem_we} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 0000",
                  {bus.busy, bus.done, bus.fault, bus.mem_we});
      end
      n_chk++;
      if (bus.rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h want 0", bus.rdata);
      end
      n_chk++;
      if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mem: got %h/%h want 0/0",
                  bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_sw_lw();
      int lat;
      logic [31:0] rd;
      logic flt;
      int w0;
      w0 = we_cnt;
      run_op(OP_SW, 32'h1001_0000, 32'h0000_0003, lat, rd, flt);
      n_chk++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL sw_lat: got %0d want 2", lat);
      end
      n_chk++;
      if (we_cnt - w0 !== 1) begin
         n_fail++;
         $display("FAIL sw_we_cnt: got %0d want 1", we_cnt - w0);
      end
      n_chk++;
      if (wr_addr !== 32'h1001_0000 || wr_data !== 32'h3) begin
         n_fail++;
         $display("FAIL sw_write: got %h/%h want 10010000/3",
                  wr_addr, wr_data);
      end
      run_op(OP_LW, 32'h1001_0000, 32'h0, lat, rd, flt);
      n_chk++;
      if (lat !== 2 || rd !== 32'h3 || flt !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_read: got lat %0d %h f%b want 2 3 f0",
                  lat, rd, flt);
      end
   endtask

   task automatic test_sb_rmw();
      int lat;
      logic [31:0] rd;
      logic flt;
      int w0;
      run_op(OP_SW, 32'h1001_0004, 32'h1122_3344, lat, rd, flt);
      w0 = we_cnt;
      run_op(OP_SB, 32'h1001_0005, 32'h0000_00AB, lat, rd, flt);
      n_chk++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL sb_lat: got %0d want 3", lat);
      end
      n_chk++;
      if (we_cnt - w0 !== 1) begin
         n_fail++;
         $display("FAIL sb_we_cnt: got %0d want 1", we_cnt - w0);
      end
      n_chk++;
      if (wr_addr !== 32'h1001_0004 || wr_data !== 32'h1122_AB44) begin
         n_fail++;
         $display("FAIL sb_write: got %h/%h want 10010004/1122ab44",
                  wr_addr, wr_data);
      end
      n_chk++;
      if (mem[1] !== 32'h1122_AB44) begin
         n_fail++;
         $display("FAIL sb_mem: got %h want 1122ab44", mem[1]);
      end
   endtask

   task automatic test_loads();
      op_e         ops [4];
      logic [31:0] offs [4];
      logic [31:0] exps [4];
      int lat;
      logic [31:0] rd;
      logic flt;
      ops[0] = OP_LB;  offs[0] = 0; exps[0] = 32'hFFFF_FF80;
      ops[1] = OP_LBU; offs[1] = 0; exps[1] = 32'h0000_0080;
      ops[2] = OP_LH;  offs[2] = 2; exps[2] = 32'hFFFF_8000;
      ops[3] = OP_LHU; offs[3] = 2; exps[3] = 32'h0000_8000;
      run_op(OP_SW, 32'h1001_0008, 32'h8000_0080, lat, rd, flt);
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], 32'h1001_0008 + offs[i], 32'h0,
                lat, rd, flt);
         n_chk++;
         if (lat !== 2 || rd !== exps[i] || flt !== 1'b0) begin
            n_fail++;
            $display("FAIL load_%0d: got lat %0d %h f%b want 2 %h f0",
                     i, lat, rd, flt, exps[i]);
         end
      end
   endtask

   task automatic test_fault();
      op_e         ops [4];
      logic [31:0] adrs [4];
      int lat;
      logic [31:0] rd;
      logic flt;
      int w0;
      ops[0] = OP_LW; adrs[0] = 32'h1001_0002;
      ops[1] = OP_SW; adrs[1] = 32'h0000_0000;
      ops[2] = OP_LB; adrs[2] = 32'h1001_1000;
      ops[3] = OP_SH; adrs[3] = 32'h1000_FFFE;
      for (int i = 0; i < 4; i++) begin
         w0 = we_cnt;
         run_op(ops[i], adrs[i], 32'hDEAD_BEEF, lat, rd, flt);
         n_chk++;
         if (lat !== 1 || flt !== 1'b1 || rd !== 32'h0 ||
             we_cnt != w0) begin
            n_fail++;
            $display("FAIL fault_%0d: got lat %0d f%b %h we%0d want 1 f1 0 we0",
                     i, lat, flt, rd, we_cnt - w0);
         end
      end
      run_op(OP_SW, 32'h1001_0FFC, 32'h5A5A_A5A5, lat, rd, flt);
      run_op(OP_LBU, 32'h1001_0FFF, 32'h0, lat, rd, flt);
      n_chk++;
      if (lat !== 2 || flt !== 1'b0 || rd !== 32'h0000_005A) begin
         n_fail++;
         $display("FAIL top_byte: got lat %0d f%b %h want 2 f0 5a",
                  lat, flt, rd);
      end
   endtask

   task automatic test_reset_abort();
      int w0;
      w0 = we_cnt;
      @(negedge clk);
      bus.req   = 1'b1;
      bus.op    = OP_SH;
      bus.addr  = 32'h1001_0008;
      bus.wdata = 32'h0000_1234;
      @(posedge clk);
      @(negedge clk);
      bus.req = 1'b0;
      n_chk++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_busy: got %b want 1", bus.busy);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if ({bus.busy, bus.done, bus.fault, bus.mem_we} !== 4'b0 ||
          bus.rdata !== 32'h0 || bus.mem_addr !== 32'h0 ||
          bus.mem_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL abort_outs: got %b %h %h %h want all 0",
                  {bus.busy, bus.done, bus.fault, bus.mem_we},
                  bus.rdata, bus.mem_addr, bus.mem_wdata);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (we_cnt != w0 || mem[2] !== 32'h8000_0080) begin
         n_fail++;
         $display("FAIL abort_mem: got we%0d %h want we0 80000080",
                  we_cnt - w0, mem[2]);
      end
   endtask

   task automatic test_back_to_back();
      int lat1;
      int lat2;
      int w0;
      logic [31:0] rd;
      w0   = we_cnt;
      lat1 = -1;
      lat2 = -1;
      rd   = '0;
      @(negedge clk);
      bus.req   = 1'b1;
      bus.op    = OP_SW;
      bus.addr  = 32'h1001_000C;
      bus.wdata = 32'hCAFE_F00D;
      @(posedge clk);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (bus.done) begin
            lat1 = i;
            bus.op    = OP_LW;
            bus.wdata = 32'h0;
            break;
         end
      end
      n_chk++;
      if (lat1 !== 2 || we_cnt - w0 !== 1) begin
         n_fail++;
         $display("FAIL b2b_sw: got lat %0d we%0d want 2 we1",
                  lat1, we_cnt - w0);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_nobubble: got busy%b done%b want 1 0",
                  bus.busy, bus.done);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         bus.req = 1'b0;
         if (bus.done) begin
            lat2 = i;
            rd   = bus.rdata;
            break;
         end
      end
      n_chk++;
      if (lat2 !== 2 || rd !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL b2b_lw: got lat %0d %h want 2 cafef00d",
                  lat2, rd);
      end
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.req   = 1'b0;
      bus.op    = OP_LB;
      bus.addr  = '0;
      bus.wdata = '0;
      test_reset();
      test_sw_lw();
      test_sb_rmw();
      test_loads();
      test_fault();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter BASE_ADDR, 32'h1001_0000, byte address of the first data-memory word.
REQ-002 Parameter DEPTH_WORDS, 1024, number of 32-bit words in data memory.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  pipeline request valid, sampled when accepted.
REQ-006 op  in  3  access type: 000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW.
REQ-007 addr  in  32  byte address (ALU result).
REQ-008 wdata  in  32  store data; low byte/halfword used for SB/SH.
REQ-009 busy  out  1  stall request to the pipeline.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  load result, sign/zero-extended; valid while done=1.
REQ-012 fault  out  1  misaligned or out-of-range access; valid while done=1.
REQ-013 mem_addr  out  32  word-aligned byte address to data memory.
REQ-014 mem_wdata  out  32  full-word write data to data memory.
REQ-015 mem_we  out  1  memory write enable; memory commits on the rising edge while high.
REQ-016 mem_rdata  in  32  memory read data, combinational from mem_addr.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS, RMW_WRITE and RESP.
REQ-018 In IDLE or RESP with req=1, the block SHALL latch op, addr and wdata at the edge and enter ACCESS, or RESP if faulted.
REQ-019 busy SHALL be 1 exactly in ACCESS and RMW_WRITE.
REQ-020 done SHALL be 1 exactly in RESP.
REQ-021 mem_addr SHALL equal {addr_q[31:2],2'b00} in ACCESS and RMW_WRITE, and hold its last value otherwise.
REQ-022 For loads, ACCESS SHALL capture the extracted, extended lane from mem_rdata and go to RESP, so done is asserted 2 cycles after acceptance.
REQ-023 For SW, ACCESS SHALL drive mem_we=1 with mem_wdata=wdata_q and go to RESP, so done is asserted 2 cycles after acceptance.
REQ-024 For SB/SH, ACCESS SHALL register mem_rdata with the addressed lane replaced and go to RMW_WRITE.
REQ-025 RMW_WRITE SHALL drive mem_we=1 with the merged word and go to RESP, so done is asserted 3 cycles after acceptance.
REQ-026 Lanes are little-endian: byte k occupies bits [8k+7:8k] and halfword h occupies bits [16h+15:16h].
REQ-027 LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
REQ-028 Misaligned accesses (LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0) SHALL fault.
REQ-029 Accesses with addr < BASE_ADDR or addr > BASE_ADDR+4*DEPTH_WORDS-1 SHALL fault.
REQ-030 A faulted request SHALL go directly to RESP with fault=1 and rdata=0, and mem_we SHALL never be asserted for it.
REQ-031 fault SHALL be 0 in every state other than a faulted RESP.
REQ-032 mem_we SHALL be 0 in IDLE and RESP.
REQ-033 RESP with req=0 SHALL return to IDLE; RESP with req=1 SHALL accept the new request with no bubble.
REQ-034 req arriving while busy=1 SHALL be ignored; the pipeline holds req stable while stalled.

Reset
REQ-035 When reset=1 at an edge, the block SHALL enter IDLE and clear busy, done, fault, rdata, mem_addr, mem_wdata, mem_we and all latched request registers to 0.
REQ-036 A reset during ACCESS or RMW_WRITE SHALL abandon the access, with mem_we=0 from that edge onward, so no partial write occurs.
REQ-037 reset SHALL take priority over req.

Structure
REQ-038 Package lsu_pkg SHALL hold the op encodings, the FSM state encoding and the BASE_ADDR/DEPTH_WORDS defaults.
REQ-039 Lane extract/extend and lane merge SHALL be a combinational sub-module named lsu_byte_lane.
REQ-040 The FSM, request registers and range/alignment check SHALL reside in lsu_ctrl.

Verification
REQ-041 SW addr=0x1001_0000, wdata=0x0000_0003 -> a single mem_we=1 cycle with mem_addr 0x1001_0000 and mem_wdata 0x0000_0003; a following LW returns 0x0000_0003 with done 2 cycles after acceptance.
REQ-042 Word 0x1122_3344 at 0x1001_0004, then SB 0xAB at 0x1001_0005 -> written word 0x1122_AB44, done 3 cycles after acceptance, mem_we high for exactly 1 cycle.
REQ-043 Word 0x8000_0080 at 0x1001_0008 -> LB @+0 returns 0xFFFF_FF80; LBU @+0 returns 0x0000_0080; LH @+2 returns 0xFFFF_8000; LHU @+2 returns 0x0000_8000.
REQ-044 LW at 0x1001_0002 and SW at 0x0000_0000 -> fault=1, done=1 and rdata=0 at 1 cycle after acceptance; mem_we stays 0.
REQ-045 SH issued, then reset asserted during ACCESS -> mem_we never asserts, all outputs are 0 after the edge, and memory is unchanged.
REQ-046 req held high across RESP with LW after SW -> second access enters ACCESS on the edge leaving RESP, with no IDLE cycle.
